// File: rtl/move_button_conditioner.sv
// move_button_conditioner
// Turns the raw Left/Right push-buttons into clean move requests for the game
// core. Each button is synchronised and debounced, and each press is latched
// until the next movement tick. A held button auto-repeats.
//
// Ports:
//   CLK      - system clock (only clock)
//   clear_n  - asynchronous active-low reset
//   Left     - raw left button, active-high, asynchronous to CLK
//   Right    - raw right button, active-high, asynchronous to CLK
//   tick     - one-cycle strobe marking a game movement step
//   left_mv  - move-left request, updated only on tick
//   right_mv - move-right request, updated only on tick
//   left_db  - debounced level of Left
//   right_db - debounced level of Right
module move_button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned REPEAT_TICKS    = 3
) (
    input  logic CLK,
    input  logic clear_n,
    input  logic Left,
    input  logic Right,
    input  logic tick,
    output logic left_mv,
    output logic right_mv,
    output logic left_db,
    output logic right_db
);

    localparam int unsigned         HOLD_W   = $clog2(REPEAT_TICKS + 1);
    localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0]   HOLD_MAX = HOLD_W'(REPEAT_TICKS);

    logic [1:0] raw_c;
    logic [1:0] stable_c;
    logic [1:0] req_c;

    // Channel 0 is Left, channel 1 is Right.
    assign raw_c = {Right, Left};

    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        logic              sync1;
        logic              sync2;
        logic              stable;
        logic              pend;
        logic [CNT_W-1:0]  cnt;
        logic [HOLD_W-1:0] hold;
        logic              rise_c;

        // The stable level goes 0->1 on this clock edge.
        assign rise_c = sync2 & ~stable & (cnt == CNT_MAX);

        // Request as seen at a tick, before the hold counter advances.
        assign req_c[ch]    = pend | rise_c | (stable & (hold == HOLD_MAX));
        assign stable_c[ch] = stable;

        // Synchroniser, debounce, press latch and hold-to-repeat counter.
        always_ff @(posedge CLK or negedge clear_n) begin
            if (!clear_n) begin
                sync1  <= 1'b0;
                sync2  <= 1'b0;
                stable <= 1'b0;
                cnt    <= '0;
                pend   <= 1'b0;
                hold   <= '0;
            end else begin
                sync1 <= raw_c[ch];
                sync2 <= sync1;

                if (sync2 == stable) begin
                    cnt <= '0;
                end else if (cnt == CNT_MAX) begin
                    stable <= sync2;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end

                // A tick coinciding with the rise consumes the press directly.
                if (tick) begin
                    pend <= 1'b0;
                end else if (rise_c) begin
                    pend <= 1'b1;
                end

                if (!stable) begin
                    hold <= '0;
                end else if (tick && (hold != HOLD_MAX)) begin
                    hold <= hold + HOLD_W'(1);
                end
            end
        end
    end

    // Move requests change only on tick; simultaneous requests cancel.
    always_ff @(posedge CLK or negedge clear_n) begin
        if (!clear_n) begin
            left_mv  <= 1'b0;
            right_mv <= 1'b0;
        end else if (tick) begin
            if (&req_c) begin
                left_mv  <= 1'b0;
                right_mv <= 1'b0;
            end else begin
                left_mv  <= req_c[0];
                right_mv <= req_c[1];
            end
        end
    end

    assign left_db  = stable_c[0];
    assign right_db = stable_c[1];

endmodule

// File: tb/tb_move_button_conditioner.sv
// Bench for move_button_conditioner: a behavioural model predicts the outputs
// after every clock edge, the driver queues the prediction, and a monitor pops
// and compares after each edge.
module tb_move_button_conditioner;

    localparam int DC = 4;
    localparam int N  = 3;

    logic CLK = 1'b0;
    logic clear_n = 1'b0;
    logic Left = 1'b0;
    logic Right = 1'b0;
    logic tick = 1'b0;
    logic left_mv;
    logic right_mv;
    logic left_db;
    logic right_db;

    int n_cmp = 0;
    int n_err = 0;
    int gcyc  = 0;

    logic [3:0] exp_q[$];

    // Model state per channel (0 = Left, 1 = Right).
    bit p1_m[2];
    bit p2_m[2];
    bit stable_m[2];
    int run_m[2];
    bit pend_m[2];
    int hold_m[2];
    bit mv_m[2];

    move_button_conditioner #(
        .DEBOUNCE_CYCLES(DC),
        .CNT_W(16),
        .REPEAT_TICKS(N)
    ) dut (
        .CLK(CLK),
        .clear_n(clear_n),
        .Left(Left),
        .Right(Right),
        .tick(tick),
        .left_mv(left_mv),
        .right_mv(right_mv),
        .left_db(left_db),
        .right_db(right_db)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic act, input bit exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %b, expected %b", name, gcyc, act, exp);
        end
    endtask

    // Behavioural model of one clock edge with the given inputs.
    task automatic model_edge(input bit l, input bit r, input bit t, input bit rn);
        bit raw[2];
        bit req[2];
        bit rise;
        bit old_s2;
        bit old_st;
        raw[0] = l;
        raw[1] = r;
        if (!rn) begin
            for (int ch = 0; ch < 2; ch++) begin
                p1_m[ch] = 0; p2_m[ch] = 0; stable_m[ch] = 0; run_m[ch] = 0;
                pend_m[ch] = 0; hold_m[ch] = 0; mv_m[ch] = 0;
            end
            return;
        end
        for (int ch = 0; ch < 2; ch++) begin
            old_s2 = p2_m[ch];
            old_st = stable_m[ch];
            rise   = 0;
            // Count consecutive disagreeing cycles; the DC-th one flips the level.
            if (old_s2 != old_st) begin
                run_m[ch]++;
                if (run_m[ch] == DC) begin
                    stable_m[ch] = old_s2;
                    run_m[ch]    = 0;
                    rise         = old_s2;
                end
            end else begin
                run_m[ch] = 0;
            end
            req[ch] = pend_m[ch] || rise || (old_st && hold_m[ch] == N);
            if (!old_st) hold_m[ch] = 0;
            else if (t && hold_m[ch] < N) hold_m[ch]++;
            if (t) pend_m[ch] = 0;
            else if (rise) pend_m[ch] = 1;
            p2_m[ch] = p1_m[ch];
            p1_m[ch] = raw[ch];
        end
        if (t) begin
            if (req[0] && req[1]) begin
                mv_m[0] = 0;
                mv_m[1] = 0;
            end else begin
                mv_m[0] = req[0];
                mv_m[1] = req[1];
            end
        end
    endtask

    function automatic bit will_rise(input int ch);
        return p2_m[ch] && !stable_m[ch] && (run_m[ch] == DC - 1);
    endfunction

    // Drive one cycle's inputs (between edges) and queue the prediction.
    task automatic step(input bit l, input bit r, input bit t, input bit rn);
        Left    = l;
        Right   = r;
        tick    = t;
        clear_n = rn;
        model_edge(l, r, t, rn);
        exp_q.push_back({stable_m[0], stable_m[1], mv_m[0], mv_m[1]});
        gcyc++;
        @(negedge CLK);
    endtask

    task automatic run(input int n, input bit l, input bit r, input int period);
        for (int i = 0; i < n; i++) step(l, r, (gcyc % period) == (period - 1), 1'b1);
    endtask

    // Monitor: compare each edge's outputs against the queued prediction.
    initial begin
        logic [3:0] e;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("left_db",  left_db,  e[3]);
                chk("right_db", right_db, e[2]);
                chk("left_mv",  left_mv,  e[1]);
                chk("right_mv", right_mv, e[0]);
            end
        end
    end

    // Reset must clear every output without waiting for a clock edge.
    always @(negedge clear_n) begin
        #1;
        chk("async_left_mv",  left_mv,  1'b0);
        chk("async_right_mv", right_mv, 1'b0);
        chk("async_left_db",  left_db,  1'b0);
        chk("async_right_db", right_db, 1'b0);
    end

    initial begin
        int rem[2];
        bit lvl[2];
        bit t;
        bit rn;
        rem[0] = 0; rem[1] = 0; lvl[0] = 0; lvl[1] = 0;

        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);

        // Single press of Left, released before being held long.
        run(20, 1, 0, 8);
        run(40, 0, 0, 8);

        // Right chattering every cycle never debounces.
        for (int i = 0; i < 30; i++) step(0, (i % 2) == 0, (gcyc % 8) == 7, 1'b1);
        run(20, 0, 0, 8);

        // Right held across many ticks for auto-repeat.
        run(60, 0, 1, 8);
        run(20, 0, 0, 8);

        // Both pressed together cancel.
        run(30, 1, 1, 8);
        run(30, 0, 0, 8);

        // Reset mid-hold with Left still pressed.
        run(40, 1, 0, 6);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        run(50, 1, 0, 6);
        run(20, 0, 0, 6);

        // Tick aligned with the debounced rise, then regular ticks.
        for (int i = 0; i < 12; i++) step(1, 0, will_rise(0), 1'b1);
        run(20, 1, 0, 7);
        run(20, 0, 0, 7);

        // Aligned rise followed immediately by back-to-back ticks.
        for (int i = 0; i < 12; i++) begin
            t = will_rise(1) || (i >= 9);
            step(0, 1, t, 1'b1);
        end
        run(20, 0, 0, 5);

        // Randomised button runs, random ticks and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            for (int ch = 0; ch < 2; ch++) begin
                if (rem[ch] == 0) begin
                    lvl[ch] = 1'($urandom_range(0, 1));
                    rem[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60))
                                                          : int'($urandom_range(1, 8));
                end
                rem[ch]--;
            end
            t  = ($urandom_range(0, 5) == 0);
            rn = ($urandom_range(0, 599) != 0);
            step(lvl[0], lvl[1], t, rn);
        end
        run(10, 0, 0, 4);

        @(posedge CLK);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/move_button_conditioner.md
# move_button_conditioner

Conditions the raw Left/Right push-buttons into clean, one-step-per-game-tick move requests for the falling-object game core. Sits directly upstream of the game logic: it synchronises and debounces both buttons in the CLK domain, latches each press until the next game movement tick, and adds hold-to-repeat. Each press therefore moves the player exactly once, however short or long the press is relative to the movement clock.

## Interface
- DEBOUNCE_CYCLES, 50000: consecutive CLK cycles the synchronised input must disagree with the stable level before the stable level flips (1 ms at 50 MHz). Must be ≥ 2.
- CNT_W, 16: debounce counter width. Must hold DEBOUNCE_CYCLES-1.
- REPEAT_TICKS, 3: ticks a button must be held before auto-repeat begins. Must be ≥ 1.

- CLK, in, 1: system clock; the only clock.
- clear_n, in, 1: asynchronous, active-low reset.
- Left, in, 1: raw left button, active-high, asynchronous to CLK.
- Right, in, 1: raw right button, active-high, asynchronous to CLK.
- tick, in, 1: single-CLK-cycle strobe marking one game movement step.
- left_mv, out, 1: move-left request, held for one full tick period.
- right_mv, out, 1: move-right request, held for one full tick period.
- left_db, out, 1: debounced level of Left.
- right_db, out, 1: debounced level of Right.

## Operation
The block has two identical channels, L and R. Each channel contains the following registers.
- Synchroniser: two flops, sync2 = input delayed by 2 cycles.
- Debounce:
  - If sync2 == stable, cnt <= 0.
  - Else, if cnt == DEBOUNCE_CYCLES-1, then stable <= sync2 and cnt <= 0.
  - Else cnt <= cnt+1.
  - Any agreeing cycle restarts the count.
  - *_db = stable.
- Press latch pend:
  - Set on a stable 0→1 transition.
  - Cleared on tick.
  - If the rising transition and tick occur in the same cycle, that tick consumes the press and pend stays 0.
- Hold counter hold (0..REPEAT_TICKS):
  - Reset to 0 whenever stable == 0.
  - On tick with stable == 1, increments and saturates at REPEAT_TICKS.
- Request at tick, computed before the hold update:
  - req = pend | rise_this_cycle | (stable && hold == REPEAT_TICKS).
- Output register, updated only on tick:
  - If req_L && req_R, then left_mv <= 0 and right_mv <= 0 (conflict cancels both; pends still cleared).
  - Otherwise left_mv <= req_L and right_mv <= req_R.
  - Between ticks the outputs hold their value.
- A button released before its tick still produces exactly one request at the next tick.
- A press and release that both complete between two ticks yields one request. A second full press in the same interval is merged into it.

## Timing
- Reset values: all outputs 0; sync flops, stable, cnt, pend and hold all 0.
- Press-to-stable latency: an input held from cycle t makes *_db rise at t+2+DEBOUNCE_CYCLES. Release latency is identical.
- Glitches shorter than DEBOUNCE_CYCLES cycles (after synchronisation) never change *_db.
- Stable-to-output latency: from the rising edge of stable to the first tick, *_mv changes on the CLK edge that samples tick=1, and stays valid until the next tick edge.
- Auto-repeat: with REPEAT_TICKS=N, ticks 1, N+1, N+2, … after the press all assert the request while the button is held.
- Reset mid-operation: all state clears immediately (asynchronous).
- After clear_n deasserts, a button still held must re-debounce. It then rises as a fresh press and produces one request.
- tick asserted on consecutive cycles is legal; each cycle is a separate tick.

## Test plan
Simulate with DEBOUNCE_CYCLES=4 and REPEAT_TICKS=3.
- Hold Left high for 20 cycles, then low. left_db rises at press+6. The next tick sets left_mv=1 for exactly one tick period; the following tick clears it. right_mv stays 0 throughout.
- Toggle Right every cycle for 30 cycles, then hold it low. right_db remains 0 and right_mv is never asserted.
- Hold Right across 6 ticks. right_mv is 1 after tick1, 0 after tick2, 0 after tick3, and 1 after each of tick4, tick5 and tick6.
- Press Left and Right together and hold both through one tick. Both outputs are 0 after that tick, and both pends are cleared (checked with an internal probe or by the following tick producing 0 after release).
- Pulse clear_n low mid-hold, with left_mv=1 and hold saturated. All outputs are 0 asynchronously. After release, with Left still high, left_db rises 6 cycles later and the next tick gives left_mv=1. Auto-repeat restarts from hold=0.
- Align the debounced rising edge of Left with the tick cycle. left_mv=1 after that tick, and it is 0 after the next tick (no double count).
